// File: rtl/store_write_buffer_if.sv
// Bus bundle for the store write buffer: pipeline store/load side plus the memory drain port.
// The slave modport is the buffer's view; master is the pipeline/memory side driving it.
interface store_write_buffer_if #(
  parameter int AW = 32
);
  logic [1:0]    memwrite;
  logic [AW-1:0] dataadr;
  logic [31:0]   writedata;
  logic          stall;
  logic          misalign;
  logic [AW-1:0] ld_addr;
  logic [3:0]    ld_fwd_mask;
  logic [31:0]   ld_fwd_data;
  logic          mem_we;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic          empty;

  modport slave (
    input  memwrite, dataadr, writedata, ld_addr, mem_ready,
    output stall, misalign, ld_fwd_mask, ld_fwd_data,
    output mem_we, mem_addr, mem_be, mem_wdata, empty
  );

  modport master (
    output memwrite, dataadr, writedata, ld_addr, mem_ready,
    input  stall, misalign, ld_fwd_mask, ld_fwd_data,
    input  mem_we, mem_addr, mem_be, mem_wdata, empty
  );
endinterface

// File: rtl/store_write_buffer.sv
// Store write buffer: lane-aligns MIPS sb/sh/sw stores, queues them in a small FIFO,
// drains them over a valid/ready port and forwards buffered bytes to loads.
module store_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input logic                clk,
  input logic                reset,
  store_write_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int WA = AW - 2;

  typedef enum logic [1:0] {
    ST_NONE = 2'b00,
    ST_SW   = 2'b01,
    ST_SH   = 2'b10,
    ST_SB   = 2'b11
  } store_op_e;

  logic [WA-1:0] addr_q [DEPTH];
  logic [3:0]    be_q   [DEPTH];
  logic [31:0]   data_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          misalign_q, misalign_d;

  logic          store_req, aligned, full, push, pop;
  logic [3:0]    be_in;
  logic [31:0]   data_in;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    aligned = 1'b0;
    be_in   = '0;
    data_in = '0;
    case (store_op_e'(bus.memwrite))
      ST_SB: begin
        aligned = 1'b1;
        be_in   = 4'b0001 << bus.dataadr[1:0];
        data_in = {24'h0, bus.writedata[7:0]} << {bus.dataadr[1:0], 3'b000};
      end
      ST_SH: begin
        aligned = ~bus.dataadr[0];
        be_in   = bus.dataadr[1] ? 4'b1100 : 4'b0011;
        data_in = bus.dataadr[1] ? {bus.writedata[15:0], 16'h0} : {16'h0, bus.writedata[15:0]};
      end
      ST_SW: begin
        aligned = (bus.dataadr[1:0] == 2'b00);
        be_in   = 4'b1111;
        data_in = bus.writedata;
      end
      ST_NONE: ;
    endcase
  end

  assign store_req = (bus.memwrite != ST_NONE);
  assign full      = (count_q == (PW+1)'(DEPTH));
  assign push      = store_req & aligned & ~full;
  assign pop       = (count_q != '0) & bus.mem_ready;

  // A pop at the same edge cannot make room for a held store: the pipeline retries next cycle.
  assign bus.stall    = store_req & aligned & full;
  assign bus.misalign = misalign_q;
  assign bus.mem_we   = (count_q != '0);
  assign bus.empty    = (count_q == '0);
  assign bus.mem_addr = {addr_q[rd_ptr_q], 2'b00};
  assign bus.mem_be   = be_q[rd_ptr_q];
  assign bus.mem_wdata = data_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    misalign_d = store_req & ~aligned;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

  // NOTE: entry storage has no reset; count gates every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= bus.dataadr[AW-1:2];
      be_q[wr_ptr_q]   <= be_in;
      data_q[wr_ptr_q] <= data_in;
    end
  end

  // Walk entries oldest to youngest so a younger hit overwrites an older one per lane.
  logic [PW-1:0] fwd_idx;
  logic [3:0]    fwd_mask;
  logic [31:0]   fwd_data;

  always_comb begin
    fwd_mask = '0;
    fwd_data = '0;
    fwd_idx  = rd_ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr_q + PW'(i);
      if (((PW+1)'(i) < count_q) && (addr_q[fwd_idx] == bus.ld_addr[AW-1:2])) begin
        for (int b = 0; b < 4; b++) begin
          if (be_q[fwd_idx][b]) begin
            fwd_mask[b]        = 1'b1;
            fwd_data[8*b +: 8] = data_q[fwd_idx][8*b +: 8];
          end
        end
      end
    end
  end

  assign bus.ld_fwd_mask = fwd_mask;
  assign bus.ld_fwd_data = fwd_data;

  logic unused_ld_offset;
  assign unused_ld_offset = ^bus.ld_addr[1:0];
endmodule
